// File: rtl/mp_add_seq.sv
// Sequential 64-bit add/subtract unit: four 16-bit beats through one adder slice.
// Optional operation counter output op_cnt enabled by defining MP_ADD_SEQ_OPCNT_EN.
module mp_add_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] op_a,
  input  logic [63:0] op_b,
  input  logic        sub,
  input  logic        cin,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] res,
  output logic        cout,
  output logic        ovf
`ifdef MP_ADD_SEQ_OPCNT_EN
  ,
  output logic [15:0] op_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [63:0] r_a;
  logic [63:0] r_b;
  logic [63:0] r_res;
  logic        r_sub;
  logic        r_carry;
  logic        r_cout;
  logic        r_ovf;
  logic [1:0]  r_beat;

  logic [15:0] w_sliceA;
  logic [15:0] w_sliceB;
  logic [15:0] w_sum;
  logic        w_c16;
  logic        w_c15;

  // The single shared slice adder; w_c15 recovers the carry into the slice MSB.
  always_comb begin
    w_sliceA = r_a[{r_beat, 4'b0000} +: 16];
    w_sliceB = r_sub ? ~r_b[{r_beat, 4'b0000} +: 16] : r_b[{r_beat, 4'b0000} +: 16];
    {w_c16, w_sum} = {1'b0, w_sliceA} + {1'b0, w_sliceB} + {16'b0, r_carry};
    w_c15 = w_sum[15] ^ w_sliceA[15] ^ w_sliceB[15];
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = RUN;
      RUN:     if (r_beat == 2'd3) w_next = DONE;
      DONE:    if (res_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sub   <= 1'b0;
      r_carry <= 1'b0;
      r_beat  <= 2'd0;
      r_res   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && in_valid) begin
        r_a     <= op_a;
        r_b     <= op_b;
        r_sub   <= sub;
        r_carry <= sub | cin;
        r_beat  <= 2'd0;
      end else if (r_state == RUN) begin
        r_res[{r_beat, 4'b0000} +: 16] <= w_sum;
        r_carry <= w_c16;
        r_beat  <= r_beat + 2'd1;
        if (r_beat == 2'd3) begin
          r_cout <= w_c16;
          r_ovf  <= w_c16 ^ w_c15;
        end
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign res_valid = (r_state == DONE);
  assign res       = r_res;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

`ifdef MP_ADD_SEQ_OPCNT_EN
  logic [15:0] r_opCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_opCnt <= 16'd0;
    else if (r_state == DONE && res_ready)
      r_opCnt <= r_opCnt + 16'd1;
  end

  assign op_cnt = r_opCnt;
`endif

endmodule

// File: tb/tb_mp_add_seq.sv
// Self-checking bench for mp_add_seq: directed table, randomized model checks, corner sequences.
module tb_mp_add_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] op_a;
  logic [63:0] op_b;
  logic        sub;
  logic        cin;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] res;
  logic        cout;
  logic        ovf;
`ifdef MP_ADD_SEQ_OPCNT_EN
  logic [15:0] op_cnt;
`endif

  mp_add_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .cin       (cin),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res       (res),
    .cout      (cout),
    .ovf       (ovf)
`ifdef MP_ADD_SEQ_OPCNT_EN
    ,
    .op_cnt    (op_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        s;
    logic        c;
    logic [63:0] expRes;
    logic        expCout;
    logic        expOvf;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;

  // Reference: whole-word 65-bit arithmetic, overflow from operand/result signs.
  function automatic logic [65:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic s, input logic c);
    logic [63:0] bb;
    logic [64:0] sum;
    logic        v;
    bb  = s ? ~b : b;
    sum = {1'b0, a} + {1'b0, bb} + 65'(s ? 1'b1 : c);
    v   = (a[63] == bb[63]) && (sum[63] != a[63]);
    return {v, sum[64], sum[63:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b,
                               input logic s, input logic c);
    int lat;
    @(negedge clk);
    checkOutput("in_ready_before_accept", {63'b0, in_ready}, 64'd1);
    op_a = a; op_b = b; sub = s; cin = c; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom};
    sub = 1'($urandom); cin = 1'($urandom);
    lat = 0;
    while (!res_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("latency", 64'(lat), 64'd4);
    checkOutput("in_ready_in_done", {63'b0, in_ready}, 64'd0);
  endtask

  task automatic releaseResult(input logic [63:0] expRes);
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    checkOutput("in_ready_after_release", {63'b0, in_ready}, 64'd1);
    checkOutput("res_valid_after_release", {63'b0, res_valid}, 64'd0);
    checkOutput("res_held_in_idle", res, expRes);
  endtask

  vec_t table_v[7];

  initial begin
    logic [65:0] m;
    logic [63:0] ra;
    logic [63:0] rb;
    logic        rs;
    logic        rc;

    table_v[0] = '{64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
    table_v[1] = '{64'd5, 64'd7, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    table_v[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0};
    table_v[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    table_v[4] = '{64'd0, 64'd0, 1'b0, 1'b1, 64'd1, 1'b0, 1'b0};
    table_v[5] = '{64'd5, 64'd5, 1'b1, 1'b1, 64'd0, 1'b1, 1'b0};
    table_v[6] = '{64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
    op_a = '0; op_b = '0; sub = 1'b0; cin = 1'b0;
    #1;
    checkOutput("reset_in_ready", {63'b0, in_ready}, 64'd1);
    checkOutput("reset_res_valid", {63'b0, res_valid}, 64'd0);
    checkOutput("reset_res", res, 64'd0);
    checkOutput("reset_flags", {62'b0, cout, ovf}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      applyStimulus(table_v[i].a, table_v[i].b, table_v[i].s, table_v[i].c);
      checkOutput($sformatf("table%0d_res", i), res, table_v[i].expRes);
      checkOutput($sformatf("table%0d_cout", i), {63'b0, cout}, {63'b0, table_v[i].expCout});
      checkOutput($sformatf("table%0d_ovf", i), {63'b0, ovf}, {63'b0, table_v[i].expOvf});
      releaseResult(table_v[i].expRes);
    end

    for (int i = 0; i < 40; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 8 == 1) rb = ~ra;
      if (i % 8 == 3) ra = 64'h7FFF_FFFF_FFFF_0000 | 64'($urandom_range(0, 65535));
      rs = 1'($urandom);
      rc = 1'($urandom);
      m = model(ra, rb, rs, rc);
      applyStimulus(ra, rb, rs, rc);
      checkOutput($sformatf("rand%0d_res", i), res, m[63:0]);
      checkOutput($sformatf("rand%0d_cout", i), {63'b0, cout}, {63'b0, m[64]});
      checkOutput($sformatf("rand%0d_ovf", i), {63'b0, ovf}, {63'b0, m[65]});
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
        checkOutput("hold_res", res, m[63:0]);
      end
      releaseResult(m[63:0]);
    end

    // Back-pressure: result must hold while new requests are offered and refused.
    ra = 64'h1234_5678_9ABC_DEF0;
    rb = 64'h0FED_CBA9_8765_4321;
    m  = model(ra, rb, 1'b0, 1'b1);
    applyStimulus(ra, rb, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = (i % 2 == 0);
      op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom};
      sub = 1'($urandom); cin = 1'($urandom);
      @(posedge clk); #1;
      checkOutput("bp_res_stable", res, m[63:0]);
      checkOutput("bp_flags_stable", {62'b0, cout, ovf}, {62'b0, m[64], m[65]});
      checkOutput("bp_in_ready", {63'b0, in_ready}, 64'd0);
      checkOutput("bp_res_valid", {63'b0, res_valid}, 64'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    releaseResult(m[63:0]);

    // Reset at beat 2 abandons the operation; next request must still work.
    @(negedge clk);
    op_a = 64'hAAAA_BBBB_CCCC_DDDD; op_b = 64'h1111_2222_3333_4444;
    sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_run_in_ready", {63'b0, in_ready}, 64'd1);
    checkOutput("rst_run_res_valid", {63'b0, res_valid}, 64'd0);
    checkOutput("rst_run_res", res, 64'd0);
    checkOutput("rst_run_flags", {62'b0, cout, ovf}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_hold_res", res, 64'd0);
    rst_n = 1'b1;
    ra = 64'hFFFF_0000_FFFF_0000;
    rb = 64'h0001_FFFF_0001_FFFF;
    m  = model(ra, rb, 1'b1, 1'b0);
    applyStimulus(ra, rb, 1'b1, 1'b0);
    checkOutput("post_rst_res", res, m[63:0]);
    checkOutput("post_rst_flags", {62'b0, cout, ovf}, {62'b0, m[64], m[65]});
    releaseResult(m[63:0]);

`ifdef MP_ADD_SEQ_OPCNT_EN
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("opcnt_reset", {48'b0, op_cnt}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; res_ready = 1'b1;
    repeat (65537 * 6) @(posedge clk);
    #1;
    in_valid = 1'b0; res_ready = 1'b0;
    checkOutput("opcnt_wrap", {48'b0, op_cnt}, 64'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
